lfsr_burst_ctrl: RTL

Sequencing controller for the 12-bit Fibonacci LFSR used as the stimulus source of the sequence-detector design. It embeds the LFSR datapath and owns seeding. On start, it runs one burst of programmed length, streaming one LFSR bit per valid/ready handshake to the downstream detector. It reports burst completion and detection of a full LFSR period.

---
 rtl/lfsr_burst_ctrl_if.sv | 8 +
 rtl/lfsr_burst_ctrl.sv | 66 ++++++
 2 files changed

// File: rtl/lfsr_burst_ctrl_if.sv
// lfsr_burst_ctrl_if: valid/ready bit stream from the LFSR controller to the detector
interface lfsr_burst_ctrl_if;
  logic bit_out;
  logic bit_valid;
  logic bit_ready;
  modport master(output bit_out, bit_valid, input bit_ready);
  modport slave(input bit_out, bit_valid, output bit_ready);
endinterface

// File: rtl/lfsr_burst_ctrl.sv
// lfsr_burst_ctrl: burst sequencer around a 12-bit Fibonacci LFSR, one bit per handshake
module lfsr_burst_ctrl #(
  parameter int N = 12,
  parameter int CNT_W = 16,
  parameter logic [N-1:0] DEFAULT_SEED = 12'hC0D
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                seed_load,
  input  logic [N-1:0]        seed_in,
  input  logic [CNT_W-1:0]    burst_len,
  lfsr_burst_ctrl_if.master   bs,
  output logic                busy,
  output logic                done,
  output logic                wrap_tick,
  output logic [CNT_W-1:0]    step_count
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [N-1:0] lfsr_reg, seed_reg, lfsr_next;
  logic [CNT_W-1:0] len_reg;
  assign lfsr_next = {lfsr_reg[N-2:0], lfsr_reg[0] ^ lfsr_reg[3] ^ lfsr_reg[5] ^ lfsr_reg[N-1]};
  assign busy = state == RUN;
  assign bs.bit_valid = state == RUN;
  assign bs.bit_out = lfsr_reg[N-1];
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      lfsr_reg <= DEFAULT_SEED;
      seed_reg <= DEFAULT_SEED;
      len_reg <= '0;
      step_count <= '0;
      done <= 1'b0;
      wrap_tick <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap_tick <= 1'b0;
      case (state)
        IDLE: begin
          // an all-zero seed would lock the LFSR, so it is dropped
          if (seed_load && seed_in != '0) begin
            seed_reg <= seed_in;
            lfsr_reg <= seed_in;
          end
          if (start) begin
            len_reg <= burst_len;
            step_count <= '0;
            state <= burst_len == '0 ? DONE : RUN;
            done <= burst_len == '0;
          end
        end
        RUN: if (bs.bit_ready) begin
          lfsr_reg <= lfsr_next;
          step_count <= step_count + CNT_W'(1);
          wrap_tick <= lfsr_next == seed_reg;
          if (step_count + CNT_W'(1) == len_reg) begin
            state <= DONE;
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
